// File: rtl/tests_stall_fifo_if.sv
// Valid/ready stream bundle for tests_stall_fifo: producer side (in_*) and consumer side (out_*).
interface tests_stall_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  // Environment view: drives producer/consumer controls, observes the buffer.
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  // Buffer view.
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/tests_stall_fifo.sv
// Test-only elastic buffer whose input and output handshakes are throttled by external stall strobes.
// Optional throttle counters are built when TESTS_STALL_FIFO_STAT_EN is defined.
module tests_stall_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_in_i,
  input  logic                  stall_out_i,
  tests_stall_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [31:0]           stat_in_stall_o,
  output logic [31:0]           stat_out_stall_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign bus.in_ready_o  = !rst && !full && !stall_in_i;
  assign bus.out_valid_o = !rst && !empty && !stall_out_i;

  assign push = bus.in_valid_i && bus.in_ready_o;
  assign pop  = bus.out_valid_o && bus.out_ready_i;

  assign bus.out_data_o = rst ? '0 : mem[rd_ptr[AW-1:0]];
  assign level_o        = rst ? '0 : PW'(wr_ptr - rd_ptr);

  // Storage and pointers; a flush drops any push landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.in_data_i;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

`ifdef TESTS_STALL_FIFO_STAT_EN
  logic [31:0] in_stall_cnt;
  logic [31:0] out_stall_cnt;

  // Saturating throttle counters, immune to flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (bus.in_valid_i && !bus.in_ready_o && (in_stall_cnt != 32'hFFFF_FFFF)) begin
        in_stall_cnt <= in_stall_cnt + 32'd1;
      end
      if (!empty && bus.out_ready_i && stall_out_i && (out_stall_cnt != 32'hFFFF_FFFF)) begin
        out_stall_cnt <= out_stall_cnt + 32'd1;
      end
    end
  end

  assign stat_in_stall_o  = rst ? '0 : in_stall_cnt;
  assign stat_out_stall_o = rst ? '0 : out_stall_cnt;
`else
  assign stat_in_stall_o  = '0;
  assign stat_out_stall_o = '0;
`endif

endmodule

// File: tb/tb_tests_stall_fifo.sv
// Self-checking bench for tests_stall_fifo: directed scenarios then randomized traffic against a queue model.
module tb_tests_stall_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic              stall_in_i = 1'b0;
  logic              stall_out_i = 1'b0;
  logic [LW-1:0]     level_o;
  logic [31:0]       stat_in_stall_o;
  logic [31:0]       stat_out_stall_o;

  tests_stall_fifo_if #(.WIDTH(WIDTH)) bus ();

  tests_stall_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .stall_in_i       (stall_in_i),
    .stall_out_i      (stall_out_i),
    .bus              (bus),
    .level_o          (level_o),
    .stat_in_stall_o  (stat_in_stall_o),
    .stat_out_stall_o (stat_out_stall_o)
  );

  always #5 clk = ~clk;

  // Reference model: ordered contents plus throttle tallies.
  logic [WIDTH-1:0] q[$];
  longint unsigned  m_in;
  longint unsigned  m_out;
  bit               mem_clean;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef TESTS_STALL_FIFO_STAT_EN
    chk("stat_in", 64'(stat_in_stall_o), (m_in > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_in);
    chk("stat_out", 64'(stat_out_stall_o), (m_out > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_out);
`else
    chk("stat_in_off", 64'(stat_in_stall_o), 64'd0);
    chk("stat_out_off", 64'(stat_out_stall_o), 64'd0);
`endif
  endtask

  // One clock cycle: drive, check visible outputs against the model, then advance the model.
  task automatic step(input logic fl, input logic si, input logic so, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy);
    logic exp_ir;
    logic exp_ov;
    @(negedge clk);
    flush_i         = fl;
    stall_in_i      = si;
    stall_out_i     = so;
    bus.in_valid_i  = iv;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
    #1;
    exp_ir = (q.size() < DEPTH) && !si;
    exp_ov = (q.size() > 0) && !so;
    chk("in_ready", 64'(bus.in_ready_o), 64'(exp_ir));
    chk("out_valid", 64'(bus.out_valid_o), 64'(exp_ov));
    chk("level", 64'(level_o), 64'(q.size()));
    if (q.size() > 0)
      chk("out_data", 64'(bus.out_data_o), 64'(q[0]));
    else if (mem_clean)
      chk("out_data_clean", 64'(bus.out_data_o), 64'd0);
    chk_stats();
    if (iv && !exp_ir) m_in++;
    if ((q.size() > 0) && ordy && so) m_out++;
    if (fl) begin
      q.delete();
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (iv && exp_ir) begin
        q.push_back(d);
        mem_clean = 1'b0;
      end
    end
  endtask

  // One reset cycle with live traffic applied; nothing may be accepted or offered.
  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    flush_i         = 1'b0;
    stall_in_i      = 1'b0;
    stall_out_i     = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 32'hDEAD_BEEF;
    bus.out_ready_i = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_out_data", 64'(bus.out_data_o), 64'd0);
    q.delete();
    m_in = 0;
    m_out = 0;
    mem_clean = 1'b1;
    chk_stats();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    m_in = 0;
    m_out = 0;
    mem_clean = 1'b1;
    do_reset();

    // First cycle after reset honours the input stall alone.
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Basic stream.
    step(0, 0, 0, 1, 32'h11, 1);
    step(0, 0, 0, 1, 32'h22, 1);
    step(0, 0, 0, 1, 32'h33, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Fill and overflow, then simultaneous pop/refused push at full.
    step(0, 0, 0, 1, 32'hA, 0);
    step(0, 0, 0, 1, 32'hB, 0);
    step(0, 0, 0, 1, 32'hC, 0);
    step(0, 0, 0, 1, 32'hD, 0);
    step(0, 0, 0, 1, 32'hE, 0);
    step(0, 0, 0, 1, 32'hE, 1);
    step(0, 0, 0, 1, 32'hE, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);

    // Output stall over two stored entries.
    step(0, 0, 0, 1, 32'h61, 0);
    step(0, 0, 0, 1, 32'h62, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Flush with a concurrent push.
    step(0, 0, 0, 1, 32'h71, 0);
    step(0, 0, 0, 1, 32'h72, 0);
    step(0, 0, 0, 1, 32'h73, 0);
    step(1, 0, 0, 1, 32'h55, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Reset mid-operation.
    step(0, 0, 0, 1, 32'h81, 0);
    step(0, 0, 0, 1, 32'h82, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(logic'($urandom_range(0, 49) == 0),
             logic'($urandom_range(0, 3) == 0),
             logic'($urandom_range(0, 3) == 0),
             logic'($urandom_range(0, 2) != 0),
             WIDTH'($urandom),
             logic'($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
